// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller: FSM state
// encodings and the default pipeline geometry.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MC_WAIT = 2'd1,
    ST_HALT    = 2'd2
  } state_e;

  localparam int DEF_NSTAGES    = 5;
  localparam int DEF_ID_IDX     = 1;
  localparam int DEF_EX_IDX     = 2;
  localparam int DEF_CNT_W      = 64;
  localparam int DEF_MC_TIMEOUT = 256;

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter: sticks at all ones instead of wrapping.
module sat_counter #(
  parameter int W = 64
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}}))
      count_d = count_q + W'(1);
  end

  always_ff @(posedge clock) begin
    if (!reset) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Stall/flush controller for an N-register in-order pipeline, with halt state,
// multi-cycle watchdog and saturating performance counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int NSTAGES    = DEF_NSTAGES,
  parameter int ID_IDX     = DEF_ID_IDX,
  parameter int EX_IDX     = DEF_EX_IDX,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int MC_TIMEOUT = DEF_MC_TIMEOUT
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               ext_stall_i,
  input  logic               mc_busy_i,
  input  logic               load_use_i,
  input  logic               branch_flush_i,
  input  logic               retire_i,
  input  logic               exit_i,
  output logic [NSTAGES-1:0] stall_o,
  output logic [NSTAGES-1:0] flush_o,
  output logic [1:0]         state_o,
  output logic               halted_o,
  output logic               err_o,
  output logic [CNT_W-1:0]   nr_insts_o,
  output logic [CNT_W-1:0]   nr_stalls_o,
  output logic [CNT_W-1:0]   nr_flushes_o
);

  localparam int WD_W = (MC_TIMEOUT > 0) ? $clog2(MC_TIMEOUT + 1) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((MC_TIMEOUT > 0) ? MC_TIMEOUT - 1 : 0);

  state_e          state_q, state_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic            err_q, err_d;
  logic            br_accept;
  logic            active;

  logic [NSTAGES-1:0] mc_stall_mask, mc_flush_mask;
  logic [NSTAGES-1:0] id_stall_mask, id_flush_mask, br_flush_mask;

  // Constant per-register masks derived from the configured stage indices.
  generate
    for (genvar gi = 0; gi < NSTAGES; gi++) begin : g_mask
      assign mc_stall_mask[gi] = (gi <= EX_IDX);
      assign mc_flush_mask[gi] = (gi == EX_IDX + 1);
      assign id_stall_mask[gi] = (gi <= ID_IDX);
      assign id_flush_mask[gi] = (gi == ID_IDX + 1);
      assign br_flush_mask[gi] = (gi == ID_IDX);
    end
  endgenerate

  always_comb begin
    stall_o   = '0;
    flush_o   = '0;
    br_accept = 1'b0;
    if (!reset) begin
      flush_o = '1;
    end else if (state_q == ST_HALT || ext_stall_i) begin
      stall_o = '1;
    end else if (mc_busy_i) begin
      stall_o = mc_stall_mask;
      flush_o = mc_flush_mask;
    end else if (load_use_i) begin
      stall_o = id_stall_mask;
      flush_o = id_flush_mask;
    end else if (branch_flush_i) begin
      flush_o   = br_flush_mask;
      br_accept = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    wd_d    = wd_q;
    err_d   = err_q;
    unique case (state_q)
      ST_RUN: begin
        wd_d = '0;
        if (!ext_stall_i) begin
          if (exit_i)         state_d = ST_HALT;
          else if (mc_busy_i) state_d = ST_MC_WAIT;
        end
      end
      ST_MC_WAIT: begin
        // ext_stall freezes both the state and the watchdog
        if (!ext_stall_i) begin
          if (exit_i) begin
            state_d = ST_HALT;
          end else if (!mc_busy_i) begin
            state_d = ST_RUN;
            wd_d    = '0;
          end else if (MC_TIMEOUT != 0 && wd_q == WD_LAST) begin
            state_d = ST_HALT;
            err_d   = 1'b1;
          end else begin
            wd_d = wd_q + WD_W'(1);
          end
        end
      end
      default: state_d = ST_HALT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= ST_RUN;
      wd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
      err_q   <= err_d;
    end
  end

  assign state_o  = state_q;
  assign halted_o = (state_q == ST_HALT);
  assign err_o    = err_q;
  assign active   = reset && (state_q != ST_HALT);

  sat_counter #(.W(CNT_W)) u_cnt_insts (
    .clock (clock),
    .reset (reset),
    .inc   (active && retire_i),
    .count (nr_insts_o)
  );

  sat_counter #(.W(CNT_W)) u_cnt_stalls (
    .clock (clock),
    .reset (reset),
    .inc   (active && stall_o[0]),
    .count (nr_stalls_o)
  );

  sat_counter #(.W(CNT_W)) u_cnt_flushes (
    .clock (clock),
    .reset (reset),
    .inc   (br_accept),
    .count (nr_flushes_o)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench: a default-parameter instance and a small one
// (CNT_W=4, MC_TIMEOUT=4) driven by the same stimulus.
module tb_pipe_ctrl;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic ext_stall_i = 1'b0, mc_busy_i = 1'b0, load_use_i = 1'b0;
  logic branch_flush_i = 1'b0, retire_i = 1'b0, exit_i = 1'b0;

  logic [4:0]  stall_o, flush_o, stall_s, flush_s;
  logic [1:0]  state_o, state_s;
  logic        halted_o, err_o, halted_s, err_s;
  logic [63:0] nr_insts_o, nr_stalls_o, nr_flushes_o;
  logic [3:0]  nr_insts_s, nr_stalls_s, nr_flushes_s;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  pipe_ctrl dut (
    .clock(clock), .reset(reset), .ext_stall_i(ext_stall_i), .mc_busy_i(mc_busy_i),
    .load_use_i(load_use_i), .branch_flush_i(branch_flush_i), .retire_i(retire_i),
    .exit_i(exit_i), .stall_o(stall_o), .flush_o(flush_o), .state_o(state_o),
    .halted_o(halted_o), .err_o(err_o), .nr_insts_o(nr_insts_o),
    .nr_stalls_o(nr_stalls_o), .nr_flushes_o(nr_flushes_o)
  );

  pipe_ctrl #(.CNT_W(4), .MC_TIMEOUT(4)) dut_s (
    .clock(clock), .reset(reset), .ext_stall_i(ext_stall_i), .mc_busy_i(mc_busy_i),
    .load_use_i(load_use_i), .branch_flush_i(branch_flush_i), .retire_i(retire_i),
    .exit_i(exit_i), .stall_o(stall_s), .flush_o(flush_s), .state_o(state_s),
    .halted_o(halted_s), .err_o(err_s), .nr_insts_o(nr_insts_s),
    .nr_stalls_o(nr_stalls_s), .nr_flushes_o(nr_flushes_s)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    #1;
  endtask

  initial begin
    // Reset held for two edges
    #1;
    check("rst_stall", 64'(stall_o), 64'h00);
    check("rst_flush", 64'(flush_o), 64'h1f);
    tick(); tick();
    check("rst_flush2", 64'(flush_o), 64'h1f);
    reset = 1'b1;
    #1;
    check("idle_stall", 64'(stall_o), 64'h00);
    check("idle_flush", 64'(flush_o), 64'h00);
    check("idle_state", 64'(state_o), 64'd0);
    check("idle_halted", 64'(halted_o), 64'd0);
    check("idle_err", 64'(err_o), 64'd0);
    check("idle_insts", nr_insts_o, 64'd0);
    check("idle_stalls", nr_stalls_o, 64'd0);
    check("idle_flushes", nr_flushes_o, 64'd0);

    // load_use together with branch: branch ignored
    load_use_i = 1'b1; branch_flush_i = 1'b1;
    #1;
    check("lu_br_stall", 64'(stall_o), 64'b00011);
    check("lu_br_flush", 64'(flush_o), 64'b00100);
    tick();
    load_use_i = 1'b0;
    #1;
    check("br_flush", 64'(flush_o), 64'b00010);
    check("br_stall", 64'(stall_o), 64'b00000);
    check("br_cnt_before", nr_flushes_o, 64'd0);
    tick();
    branch_flush_i = 1'b0;
    #1;
    check("br_cnt_after", nr_flushes_o, 64'd1);
    check("lu_stall_cnt", nr_stalls_o, 64'd1);

    // mc_busy for 5 cycles
    mc_busy_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("mc_stall_%0d", i), 64'(stall_o), 64'b00111);
      check($sformatf("mc_flush_%0d", i), 64'(flush_o), 64'b01000);
      check($sformatf("mc_state_%0d", i), 64'(state_o), (i == 0) ? 64'd0 : 64'd1);
      tick();
    end
    mc_busy_i = 1'b0;
    #1;
    check("mc_fall_state", 64'(state_o), 64'd1);
    check("mc_fall_stall", 64'(stall_o), 64'b00000);
    tick();
    check("mc_done_state", 64'(state_o), 64'd0);
    check("mc_stall_cnt", nr_stalls_o, 64'd6);

    // Reset leaves no residue in the counters
    pulse_reset();
    check("rst2_stalls", nr_stalls_o, 64'd0);
    check("rst2_flushes", nr_flushes_o, 64'd0);
    check("rst2_state_s", 64'(state_s), 64'd0);

    // Watchdog on the small instance: 4 MC_WAIT cycles then HALT
    mc_busy_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("wd_state_%0d", i), 64'(state_s), (i == 0) ? 64'd0 : 64'd1);
      check($sformatf("wd_err_%0d", i), 64'(err_s), 64'd0);
      tick();
    end
    check("wd_halt_state", 64'(state_s), 64'd2);
    check("wd_halt_err", 64'(err_s), 64'd1);
    check("wd_halted", 64'(halted_s), 64'd1);
    check("wd_halt_stall", 64'(stall_s), 64'h1f);
    check("wd_halt_flush", 64'(flush_s), 64'h00);
    check("wd_big_state", 64'(state_o), 64'd1);
    check("wd_big_err", 64'(err_o), 64'd0);
    mc_busy_i = 1'b0;
    #1;
    check("wd_halt_stall2", 64'(stall_s), 64'h1f);
    pulse_reset();
    check("wd_rst_state", 64'(state_s), 64'd0);
    check("wd_rst_err", 64'(err_s), 64'd0);

    // 10 retires, then exit with retire
    retire_i = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    exit_i = 1'b1;
    tick();
    exit_i = 1'b0;
    #1;
    check("exit_insts", nr_insts_o, 64'd11);
    check("exit_halted", 64'(halted_o), 64'd1);
    check("exit_state", 64'(state_o), 64'd2);
    for (int i = 0; i < 3; i++) tick();
    check("halt_insts", nr_insts_o, 64'd11);
    check("halt_insts_s", 64'(nr_insts_s), 64'd11);

    // Saturation on the 4-bit counter
    pulse_reset();
    for (int i = 0; i < 15; i++) tick();
    check("sat15_s", 64'(nr_insts_s), 64'd15);
    for (int i = 0; i < 5; i++) tick();
    retire_i = 1'b0;
    #1;
    check("sat20_s", 64'(nr_insts_s), 64'd15);
    check("sat20_big", nr_insts_o, 64'd20);

    // ext_stall during MC_WAIT freezes the watchdog
    pulse_reset();
    mc_busy_i = 1'b1;
    tick();
    tick();
    check("ext_pre_state", 64'(state_s), 64'd1);
    ext_stall_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      check($sformatf("ext_stall_%0d", i), 64'(stall_s), 64'h1f);
      tick();
    end
    check("ext_flush", 64'(flush_s), 64'h00);
    check("ext_hold_state", 64'(state_s), 64'd1);
    ext_stall_i = 1'b0;
    tick();
    check("ext_post1", 64'(state_s), 64'd1);
    tick();
    check("ext_post2", 64'(state_s), 64'd1);
    tick();
    check("ext_post3", 64'(state_s), 64'd2);
    check("ext_post3_err", 64'(err_s), 64'd1);
    mc_busy_i = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
